// File: rtl/if_fetch.sv
// Instruction fetch: PC register, ROM handshake and a 2-entry {pc, inst} queue to decode.
// Optional IF_FETCH_PERF_EN adds the fetch_cnt push counter.
//
// state | meaning
// IDLE  | one cycle after reset release, ROM disabled, no push
// FETCH | normal operation, push whenever the queue has (or is making) room
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [63:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [63:0] pc_mem [2];
  logic [31:0] inst_mem [2];
  logic        push, pop;
  logic [1:0]  unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  always_comb begin
    state_d  = FETCH;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    id_valid = (count_q != 2'd0);
    // Redirect wins: a flushed head is not counted as consumed.
    pop      = id_valid && id_ready && !redirect_valid;
    push     = (state_q == FETCH) && !redirect_valid && ((count_q != 2'd2) || pop);
    rom_ce   = push;
    rom_addr = pc_q;
    id_pc    = id_valid ? pc_mem[rd_ptr_q] : 64'h0;
    id_inst  = id_valid ? inst_mem[rd_ptr_q] : 32'h0;

    if (redirect_valid) begin
      pc_d     = {redirect_pc[63:2], 2'b00};
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
        pc_d     = pc_q + 64'd4;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC_ALIGNED;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_mem[0]   <= 64'h0;
      pc_mem[1]   <= 64'h0;
      inst_mem[0] <= 32'h0;
      inst_mem[1] <= 32'h0;
    end else if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= rom_inst;
    end
  end

`ifdef IF_FETCH_PERF_EN
  // Counts every push, including entries later discarded by a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= 32'h0;
    end else if (push) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, back-pressure, redirect, PC wrap and async reset.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [63:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
`endif

  int checks;
  int failures;

  if_fetch #(.RESET_PC(64'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_cnt      (fetch_cnt)
`endif
  );

  // ROM word n sits at byte address 4n.
  assign rom_inst = rom_addr[33:2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    id_ready = 1'b0;

    step(2);
    check("rst_rom_ce", {63'h0, rom_ce}, 64'h0);
    check("rst_id_valid", {63'h0, id_valid}, 64'h0);
    check("rst_id_pc", id_pc, 64'h0);
    check("rst_id_inst", {32'h0, id_inst}, 64'h0);
    check("rst_rom_addr", rom_addr, 64'h0);
`ifdef IF_FETCH_PERF_EN
    check("rst_fetch_cnt", {32'h0, fetch_cnt}, 64'h0);
`endif

    // Streaming with decode always ready
    rst = 1'b1;
    id_ready = 1'b1;
    check("idle_rom_ce", {63'h0, rom_ce}, 64'h0);
    step(1);
    check("fetch_rom_ce", {63'h0, rom_ce}, 64'h1);
    check("fetch_first_empty", {63'h0, id_valid}, 64'h0);
    step(1);
    for (int n = 0; n < 4; n++) begin
      check("stream_valid", {63'h0, id_valid}, 64'h1);
      check("stream_pc", id_pc, 64'(4 * n));
      check("stream_inst", {32'h0, id_inst}, 64'(n));
      step(1);
    end

    // Fill the queue, then reset between edges
    id_ready = 1'b0;
    step(3);
    check("full_rom_ce", {63'h0, rom_ce}, 64'h0);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_id_valid", {63'h0, id_valid}, 64'h0);
    check("async_rst_rom_ce", {63'h0, rom_ce}, 64'h0);
    check("async_rst_rom_addr", rom_addr, 64'h0);
    step(2);

    // Back-pressure from a fresh start
    rst = 1'b1;
    step(5);
    check("bp_valid", {63'h0, id_valid}, 64'h1);
    check("bp_rom_ce", {63'h0, rom_ce}, 64'h0);
    check("bp_pc_hold", rom_addr, 64'h8);
    id_ready = 1'b1;
    check("bp_head0", id_pc, 64'h0);
    step(1);
    check("bp_head1", id_pc, 64'h4);
    step(1);
    check("bp_head2", id_pc, 64'h8);
    check("bp_head2_inst", {32'h0, id_inst}, 64'h2);

    // Redirect while full
    id_ready = 1'b0;
    step(2);
    check("pre_redir_full", {63'h0, rom_ce}, 64'h0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h103;
    id_ready = 1'b1;
    #1;
    check("redir_rom_ce", {63'h0, rom_ce}, 64'h0);
    step(1);
    redirect_valid = 1'b0;
    check("redir_flush", {63'h0, id_valid}, 64'h0);
    check("redir_addr", rom_addr, 64'h100);
    step(1);
    check("redir_pc", id_pc, 64'h100);
    check("redir_inst", {32'h0, id_inst}, 64'h40);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    step(1);
    check("wrap_top_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_top_inst", {32'h0, id_inst}, 64'hFFFF_FFFF);
    step(1);
    check("wrap_zero_pc", id_pc, 64'h0);
    check("wrap_zero_inst", {32'h0, id_inst}, 64'h0);

`ifdef IF_FETCH_PERF_EN
    // Ten pushes then a redirect; flushed entries stay counted
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    id_ready = 1'b1;
    step(11);
    redirect_valid = 1'b1;
    step(1);
    redirect_valid = 1'b0;
    check("perf_cnt", {32'h0, fetch_cnt}, 64'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
